flag_register_unit: RTL

- Producer side of the condition-code path: captures ALU flags N, Z, C, V for flag-setting (S-bit) instructions, commits them through a one-stage pending register, and presents the architecturally correct NZCV to the branch condition evaluator in ID.
- Sits between the EX-stage ALU and the ID-stage condition handler.
- Provides EX/pending forwarding, or, when forwarding is disabled, a stall interlock.

---
 rtl/flag_register_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/flag_register_unit.sv
// Condition-code producer: captures ALU NZCV for flag-setting instructions, commits them
// through a one-deep pending stage, and presents forwarded flags or a stall to ID.
module flag_register_unit #(
    parameter bit         FORWARD     = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       S_EX_in,
    input  logic       EX_valid_in,
    input  logic       ALU_N_in,
    input  logic       ALU_Z_in,
    input  logic       ALU_C_in,
    input  logic       ALU_V_in,
    input  logic       C_valid_in,
    input  logic       V_valid_in,
    input  logic       Cond_use_ID_in,
    input  logic       Pipe_stall_in,
    input  logic       Flush_in,
    output logic       N_out,
    output logic       Z_out,
    output logic       C_out,
    output logic       V_out,
    output logic [3:0] Flags_reg_out,
    output logic       Stall_ID_out
);

    logic [3:0] flag_q, flag_d;
    logic       pend_valid_q, pend_valid_d;
    logic [3:0] pend_flags_q, pend_flags_d;

    logic       ex_upd;
    logic [3:0] base_flags;
    logic [3:0] ex_flags;
    logic [3:0] fwd_flags;
    logic [3:0] out_flags;
    logic       stall_raw;

    // Gating with rst_n_in keeps the outputs at the reset value while reset is held.
    assign ex_upd = S_EX_in & EX_valid_in & ~Flush_in & rst_n_in;

    // A partial update merges C/V with the newest older value, which may still be pending.
    assign base_flags = pend_valid_q ? pend_flags_q : flag_q;

    always_comb begin
        ex_flags    = base_flags;
        ex_flags[3] = ALU_N_in;
        ex_flags[2] = ALU_Z_in;
        if (C_valid_in) begin
            ex_flags[1] = ALU_C_in;
        end
        if (V_valid_in) begin
            ex_flags[0] = ALU_V_in;
        end
    end

    always_comb begin
        flag_d       = flag_q;
        pend_valid_d = pend_valid_q;
        pend_flags_d = pend_flags_q;
        if (!Pipe_stall_in) begin
            pend_valid_d = ex_upd;
            if (ex_upd) begin
                pend_flags_d = ex_flags;
            end
            if (pend_valid_q) begin
                flag_d = pend_flags_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            flag_q       <= RESET_FLAGS;
            pend_valid_q <= 1'b0;
            pend_flags_q <= 4'b0000;
        end else begin
            flag_q       <= flag_d;
            pend_valid_q <= pend_valid_d;
            pend_flags_q <= pend_flags_d;
        end
    end

    assign fwd_flags = ex_upd ? ex_flags : base_flags;
    assign stall_raw = Cond_use_ID_in & (ex_upd | pend_valid_q);

    assign out_flags    = FORWARD ? fwd_flags : flag_q;
    assign Stall_ID_out = FORWARD ? 1'b0 : stall_raw;

    assign N_out         = out_flags[3];
    assign Z_out         = out_flags[2];
    assign C_out         = out_flags[1];
    assign V_out         = out_flags[0];
    assign Flags_reg_out = flag_q;

endmodule
